// File: rtl/multi_trig_gen_pkg.sv
// Shared types and constants for the multi-channel PRF/trigger generator.
`timescale 1ns/1ps
package multi_trig_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int DEF_CNT_W = 32;

endpackage

// File: rtl/multi_trig_ch.sv
// One window comparator on the frame counter, with its output register and
// rise/fall flags that line up with the registered output change.
`timescale 1ns/1ps
module multi_trig_ch
    import multi_trig_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_delay,
    input  logic [CNT_W-1:0] i_width,
    output logic             o_win,
    output logic [1:0]       o_edge
);

    // One extra bit keeps delay+width from wrapping back into the frame.
    logic [CNT_W:0] w_cnt;
    logic [CNT_W:0] w_lo;
    logic [CNT_W:0] w_hi;
    logic           w_win;

    logic           r_win;
    logic [1:0]     r_edge;

    assign w_cnt = {1'b0, i_cnt};
    assign w_lo  = {1'b0, i_delay};
    assign w_hi  = {1'b0, i_delay} + {1'b0, i_width};
    assign w_win = i_run && i_en && (w_cnt >= w_lo) && (w_cnt < w_hi);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win  <= 1'b0;
            r_edge <= 2'b00;
        end else begin
            r_win             <= w_win;
            r_edge[EDGE_RISE] <= w_win & ~r_win;
            r_edge[EDGE_FALL] <= ~w_win & r_win;
        end
    end

    assign o_win  = r_win;
    assign o_edge = r_edge;

endmodule

// File: rtl/multi_trig_gen.sv
// PRF frame strobe, N_CH delayed trigger windows and a calibration window from
// one period counter; config is double-buffered. Optional: MULTI_TRIG_GEN_BURST_EN.
`timescale 1ns/1ps
module multi_trig_gen
    import multi_trig_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int N_CH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  update,
    input  logic [CNT_W-1:0]      cfg_period,
    input  logic [CNT_W-1:0]      cfg_prf_width,
    input  logic [CNT_W-1:0]      cfg_ct_num,
    input  logic [N_CH*CNT_W-1:0] cfg_delay,
    input  logic [N_CH*CNT_W-1:0] cfg_width,
    input  logic [N_CH-1:0]       cfg_ch_en,
`ifdef MULTI_TRIG_GEN_BURST_EN
    input  logic [CNT_W-1:0]      cfg_burst_num,
    output logic                  burst_done,
`endif
    output logic                  prf,
    output logic [1:0]            prf_edge,
    output logic [N_CH-1:0]       tr,
    output logic [2*N_CH-1:0]     tr_edge,
    output logic                  ct,
    output logic                  running,
    output logic                  applied
);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_pend_valid;
    logic [CNT_W-1:0]      r_p_period, r_p_prf_width, r_p_ct_num;
    logic [N_CH*CNT_W-1:0] r_p_delay, r_p_width;
    logic [N_CH-1:0]       r_p_ch_en;
    logic [CNT_W-1:0]      r_a_period, r_a_prf_width;
    logic [N_CH*CNT_W-1:0] r_a_delay, r_a_width;
    logic [N_CH-1:0]       r_a_ch_en;
    logic [CNT_W-1:0]      r_ct_cnt;
    logic                  r_ct;
    logic                  r_applied;
`ifdef MULTI_TRIG_GEN_BURST_EN
    logic [CNT_W-1:0]      r_p_burst_num;
    logic [CNT_W-1:0]      r_frames_left;
    logic                  r_burst_done;
`endif

    logic w_run;
    logic w_wrap;
    logic w_apply;

    assign w_run   = (r_state == RUN);
    assign w_wrap  = w_run && (r_cnt == r_a_period - 1'b1);
    assign w_apply = r_pend_valid && (!w_run || w_wrap);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_pend_valid  <= 1'b0;
            r_p_period    <= '0;
            r_p_prf_width <= '0;
            r_p_ct_num    <= '0;
            r_p_delay     <= '0;
            r_p_width     <= '0;
            r_p_ch_en     <= '0;
            r_a_period    <= '0;
            r_a_prf_width <= '0;
            r_a_delay     <= '0;
            r_a_width     <= '0;
            r_a_ch_en     <= '0;
            r_ct_cnt      <= '0;
            r_ct          <= 1'b0;
            r_applied     <= 1'b0;
`ifdef MULTI_TRIG_GEN_BURST_EN
            r_p_burst_num <= '0;
            r_frames_left <= '0;
            r_burst_done  <= 1'b0;
`endif
        end else begin
            r_applied <= w_apply;
            r_ct      <= w_run && (r_ct_cnt != '0);
`ifdef MULTI_TRIG_GEN_BURST_EN
            r_burst_done <= 1'b0;
`endif
            // An update on the apply edge becomes the next pending set.
            if (update) begin
                r_p_period    <= cfg_period;
                r_p_prf_width <= cfg_prf_width;
                r_p_ct_num    <= cfg_ct_num;
                r_p_delay     <= cfg_delay;
                r_p_width     <= cfg_width;
                r_p_ch_en     <= cfg_ch_en;
`ifdef MULTI_TRIG_GEN_BURST_EN
                r_p_burst_num <= cfg_burst_num;
`endif
                r_pend_valid  <= 1'b1;
            end else if (w_apply) begin
                r_pend_valid  <= 1'b0;
            end

            if (w_run && (r_ct_cnt != '0)) begin
                r_ct_cnt <= r_ct_cnt - 1'b1;
            end

            if (w_apply) begin
                r_a_period    <= r_p_period;
                r_a_prf_width <= r_p_prf_width;
                r_a_delay     <= r_p_delay;
                r_a_width     <= r_p_width;
                r_a_ch_en     <= r_p_ch_en;
                r_cnt         <= '0;
                // NOTE: the last non-blocking assignment wins, so this reload overrides the decrement above.
                r_ct_cnt      <= r_p_ct_num;
                r_state       <= (r_p_period == '0) ? IDLE : RUN;
`ifdef MULTI_TRIG_GEN_BURST_EN
                r_frames_left <= r_p_burst_num;
`endif
            end else if (w_wrap) begin
                r_cnt <= '0;
`ifdef MULTI_TRIG_GEN_BURST_EN
                if (r_frames_left == CNT_W'(1)) begin
                    r_state      <= IDLE;
                    r_burst_done <= 1'b1;
                end
                if (r_frames_left != '0) begin
                    r_frames_left <= r_frames_left - 1'b1;
                end
`endif
            end else if (w_run) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    multi_trig_ch #(.CNT_W(CNT_W)) u_prf (
        .clk     (clk),
        .rst     (rst),
        .i_run   (w_run),
        .i_en    (1'b1),
        .i_cnt   (r_cnt),
        .i_delay ({CNT_W{1'b0}}),
        .i_width (r_a_prf_width),
        .o_win   (prf),
        .o_edge  (prf_edge)
    );

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        multi_trig_ch #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .i_run   (w_run),
            .i_en    (r_a_ch_en[g]),
            .i_cnt   (r_cnt),
            .i_delay (r_a_delay[g*CNT_W +: CNT_W]),
            .i_width (r_a_width[g*CNT_W +: CNT_W]),
            .o_win   (tr[g]),
            .o_edge  (tr_edge[2*g +: 2])
        );
    end

    assign ct      = r_ct;
    assign running = w_run;
    assign applied = r_applied;
`ifdef MULTI_TRIG_GEN_BURST_EN
    assign burst_done = r_burst_done;
`endif

endmodule

// File: tb/tb_multi_trig_gen.sv
// Directed bench for multi_trig_gen: hand-derived frame timelines, config
// double-buffering, calibration window, boundaries and reset.
`timescale 1ns/1ps
module tb_multi_trig_gen;

    localparam int CNT_W = 32;
    localparam int N_CH  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  update;
    logic [CNT_W-1:0]      cfg_period, cfg_prf_width, cfg_ct_num;
    logic [N_CH*CNT_W-1:0] cfg_delay, cfg_width;
    logic [N_CH-1:0]       cfg_ch_en;
    logic                  prf;
    logic [1:0]            prf_edge;
    logic [N_CH-1:0]       tr;
    logic [2*N_CH-1:0]     tr_edge;
    logic                  ct, running, applied;
`ifdef MULTI_TRIG_GEN_BURST_EN
    logic [CNT_W-1:0]      cfg_burst_num;
    logic                  burst_done;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_trig_gen #(.CNT_W(CNT_W), .N_CH(N_CH)) dut (
        .clk           (clk),
        .rst           (rst),
        .update        (update),
        .cfg_period    (cfg_period),
        .cfg_prf_width (cfg_prf_width),
        .cfg_ct_num    (cfg_ct_num),
        .cfg_delay     (cfg_delay),
        .cfg_width     (cfg_width),
        .cfg_ch_en     (cfg_ch_en),
`ifdef MULTI_TRIG_GEN_BURST_EN
        .cfg_burst_num (cfg_burst_num),
        .burst_done    (burst_done),
`endif
        .prf           (prf),
        .prf_edge      (prf_edge),
        .tr            (tr),
        .tr_edge       (tr_edge),
        .ct            (ct),
        .running       (running),
        .applied       (applied)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input int d, input int w);
        cfg_delay[i*CNT_W +: CNT_W] = d;
        cfg_width[i*CNT_W +: CNT_W] = w;
    endtask

    // Steps through displayed counts j0..j1 of a frame, checking prf and tr[1:0].
    task automatic frame_chk(input string tag, input int j0, input int j1, input int pw,
                             input int d0, input int w0, input int d1, input int w1);
        for (int j = j0; j <= j1; j++) begin
            step();
            check({tag, "_prf"}, prf, (j < pw));
            check({tag, "_tr"}, tr[1:0], {(j >= d1 && j < d1 + w1), (j >= d0 && j < d0 + w0)});
        end
    endtask

    task automatic ct_run(input string tag, input int n, input int n_high);
        for (int m = 0; m < n; m++) begin
            step();
            check(tag, ct, (m < n_high));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        update = 1'b0;
        cfg_period = '0; cfg_prf_width = '0; cfg_ct_num = '0;
        cfg_delay = '0; cfg_width = '0; cfg_ch_en = '0;
`ifdef MULTI_TRIG_GEN_BURST_EN
        cfg_burst_num = '0;
`endif
        repeat (3) step();
        check("rst_prf", prf, 1'b0);
        check("rst_prf_edge", prf_edge, 2'b00);
        check("rst_tr", tr, 4'b0000);
        check("rst_tr_edge", tr_edge, 8'h00);
        check("rst_ct", ct, 1'b0);
        check("rst_running", running, 1'b0);
        check("rst_applied", applied, 1'b0);
        rst = 1'b0;
        step();

        // Basic frame from IDLE: period 10, prf 0-1, tr0 3-6, tr1 8-9 truncated.
        cfg_period = 10; cfg_prf_width = 2;
        set_ch(0, 3, 4); set_ch(1, 8, 5); set_ch(2, 0, 5); set_ch(3, 0, 5);
        cfg_ch_en = 4'b0011;
        update = 1'b1;
        step();
        update = 1'b0;
        check("t1_applied_early", applied, 1'b0);
        check("t1_running_early", running, 1'b0);
        step();
        check("t1_applied", applied, 1'b1);
        check("t1_running", running, 1'b1);
        check("t1_prf_pre", prf, 1'b0);
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 10; j++) begin
                step();
                check("t1_prf", prf, (j < 2));
                check("t1_prf_edge", prf_edge, {(j == 2), (j == 0)});
                check("t1_tr", tr, {2'b00, (j >= 8), (j >= 3 && j <= 6)});
                check("t1_tr_edge", tr_edge,
                      {4'h0, (j == 0 && f == 1), (j == 8), (j == 7), (j == 3)});
                check("t1_applied_once", applied, 1'b0);
                check("t1_ct", ct, 1'b0);
            end
        end

        // Mid-frame update to period 20: old frame completes, new period at the wrap.
        frame_chk("t3a", 0, 3, 2, 3, 4, 8, 5);
        cfg_period = 20;
        update = 1'b1;
        frame_chk("t3b", 4, 4, 2, 3, 4, 8, 5);
        update = 1'b0;
        frame_chk("t3c", 5, 9, 2, 3, 4, 8, 5);
        check("t3_applied", applied, 1'b1);
        frame_chk("t3d", 0, 19, 2, 3, 4, 8, 5);

        // Two updates before the wrap: the second (delay0=5) wins.
        set_ch(0, 2, 4);
        update = 1'b1;
        frame_chk("t4a", 0, 0, 2, 3, 4, 8, 5);
        set_ch(0, 5, 4);
        frame_chk("t4b", 1, 1, 2, 3, 4, 8, 5);
        update = 1'b0;
        frame_chk("t4c", 2, 19, 2, 3, 4, 8, 5);
        check("t4_applied", applied, 1'b1);
        frame_chk("t4d", 0, 19, 2, 5, 4, 8, 5);

        // Calibration window: 25 cycles from the first frame start, then reload to 3.
        cfg_period = 10; cfg_ct_num = 25;
        update = 1'b1;
        frame_chk("t5a", 0, 0, 2, 5, 4, 8, 5);
        update = 1'b0;
        frame_chk("t5b", 1, 19, 2, 5, 4, 8, 5);
        check("t5_applied", applied, 1'b1);
        for (int m = 0; m < 30; m++) begin
            step();
            check("t5_ct", ct, (m < 25));
            check("t5_prf", prf, ((m % 10) < 2));
        end
        cfg_ct_num = 3;
        update = 1'b1;
        ct_run("t5_ct_pend", 1, 0);
        update = 1'b0;
        ct_run("t5_ct_pend", 9, 0);
        check("t5_reapplied", applied, 1'b1);
        ct_run("t5_ct_reload", 10, 3);

        // Period 0 while running: stops at the wrap.
        cfg_period = 0;
        update = 1'b1;
        step();
        update = 1'b0;
        repeat (8) step();
        check("t6_running_before", running, 1'b1);
        step();
        check("t6_applied", applied, 1'b1);
        check("t6_running", running, 1'b0);
        step();
        check("t6_prf", prf, 1'b0);
        check("t6_tr", tr, 4'b0000);
        check("t6_ct", ct, 1'b0);
        repeat (3) step();
        check("t6_prf_edge", prf_edge, 2'b00);
        check("t6_tr_edge", tr_edge, 8'h00);
        check("t6_applied_idle", applied, 1'b0);

        // Boundaries: prf_width >= period, delay >= period, width 0, full-frame window.
        cfg_period = 5; cfg_prf_width = 7;
        set_ch(0, 6, 2); set_ch(1, 0, 5); set_ch(2, 0, 0);
        cfg_ch_en = 4'b0111;
        update = 1'b1;
        step();
        update = 1'b0;
        step();
        check("t7_applied", applied, 1'b1);
        for (int m = 0; m < 10; m++) begin
            step();
            check("t7_prf", prf, 1'b1);
            check("t7_prf_edge", prf_edge, (m == 0) ? 2'b01 : 2'b00);
            check("t7_tr", tr, 4'b0010);
            check("t7_tr_edge", tr_edge, (m == 0) ? 8'h04 : 8'h00);
        end

        // Reset mid-frame: outputs clear and the pending set is dropped.
        cfg_period = 10;
        update = 1'b1;
        step();
        update = 1'b0;
        rst = 1'b1;
        step();
        check("t8_prf", prf, 1'b0);
        check("t8_tr", tr, 4'b0000);
        check("t8_running", running, 1'b0);
        rst = 1'b0;
        repeat (3) step();
        check("t8_running_after", running, 1'b0);
        check("t8_applied_after", applied, 1'b0);

`ifdef MULTI_TRIG_GEN_BURST_EN
        begin
            int rises = 0;
            int dones = 0;
            cfg_period = 4; cfg_prf_width = 1; cfg_ct_num = 0;
            cfg_ch_en = 4'b0000; cfg_burst_num = 3;
            update = 1'b1;
            step();
            update = 1'b0;
            step();
            for (int m = 0; m < 20; m++) begin
                step();
                if (prf_edge[0]) rises++;
                if (burst_done) dones++;
            end
            check("tb_burst_rises", rises, 3);
            check("tb_burst_done", dones, 1);
            check("tb_burst_running", running, 1'b0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_trig_gen.md
Name: multi_trig_gen

Overview:
- Parametrised successor to the single-channel PRF/trigger generator.
- Produces one PRF frame strobe, N_CH independently delayed and sized trigger windows, and a calibration window (ct), all from one period counter.
- Shadow configuration is double-buffered, so updates take effect only at a frame boundary and never produce a truncated pulse.
- Sits between cmd_update (configuration) and the DDS, switch and trig outputs.

Parameters:
- CNT_W, 32, width of all clock-count fields.
- N_CH, 4, number of trigger channels.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous active-high.
- update  in  1  single-cycle pulse; latch all cfg_* inputs into the pending set.
- cfg_period  in  CNT_W  frame length in clocks; 0 stops the generator.
- cfg_prf_width  in  CNT_W  prf high time in clocks.
- cfg_ct_num  in  CNT_W  calibration window length in clocks, counted from the first frame after apply.
- cfg_delay  in  N_CH*CNT_W  per-channel start offset within the frame; channel i is bits [i*CNT_W +: CNT_W].
- cfg_width  in  N_CH*CNT_W  per-channel high time, same packing as cfg_delay.
- cfg_ch_en  in  N_CH  per-channel enable.
- prf  out  1  frame strobe.
- prf_edge  out  2  bit0 = rising edge this cycle, bit1 = falling edge this cycle.
- tr  out  N_CH  trigger windows.
- tr_edge  out  2*N_CH  per-channel edge flags, same encoding as prf_edge.
- ct  out  1  calibration window.
- running  out  1  high while a non-zero period is active.
- applied  out  1  one-cycle pulse when a pending set becomes active.

Behaviour:
- Reset: all outputs 0, state IDLE, active and pending sets cleared, pend_valid = 0.
- States:
  - IDLE: counter held at 0, all outputs 0.
  - RUN: cnt counts 0..period-1, then wraps to 0.
- Update handling:
  - update sampled at edge k copies the cfg_* inputs into the pending set and sets pend_valid.
  - A second update before apply overwrites the pending set; the last one wins.
- Apply point:
  - In IDLE: the edge after pend_valid is set.
  - In RUN: the edge where cnt == period-1.
  - At apply: active set <= pending set, cnt <= 0, pend_valid <= 0, applied pulses, ct_cnt <= cfg_ct_num.
  - If the applied period is 0, state goes to IDLE. Otherwise it goes to or stays in RUN.
- Latency: update at edge k while IDLE gives apply at k+1 and the first prf-high cycle at k+2.
  - All outputs are registered one cycle after the comparison on cnt.
- Windows are evaluated on cnt with CNT_W+1-bit arithmetic, so delay+width cannot overflow:
  - prf = (cnt < prf_width).
  - tr[i] = ch_en[i] && (cnt >= delay[i]) && (cnt < delay[i] + width[i]).
- Boundaries:
  - width = 0: channel never asserts.
  - delay >= period: channel never asserts.
  - delay + width > period: window is truncated at the wrap and does not carry into the next frame.
  - prf_width >= period: prf stays high continuously, with no edges after the first.
- Edges: edge flags compare each output with its previous registered value and are valid in the same cycle as the output change.
  - At wrap, a window that is high at period-1 and high again at cnt 0 produces no edge.
- ct:
  - ct = (ct_cnt != 0).
  - ct_cnt decrements every RUN cycle and saturates at 0.
  - A new apply reloads ct_cnt.
- Simultaneous update and apply edge: the apply uses the previous pending set. The new update becomes pending and is applied at the next wrap.
- Reset mid-frame: immediate return to the IDLE reset values; the pending set is lost.

Optional Feature:
- MULTI_TRIG_GEN_BURST_EN
  - Defined: adds input cfg_burst_num (CNT_W bits, latched with the other cfg_* inputs) and output burst_done (1 bit, one-cycle pulse).
  - A non-zero burst_num runs exactly that many frames after apply, then goes to IDLE and pulses burst_done in the cycle after the last frame's period-1.
  - burst_num = 0 means free-running. A pending apply at the final wrap takes precedence and restarts counting.
  - Undefined: the port and output are absent, and the generator is always free-running.

Decomposition:
- Package multi_trig_gen_pkg:
  - State enum (IDLE, RUN).
  - Edge-bit index constants EDGE_RISE = 0, EDGE_FALL = 1.
  - Default CNT_W.
- Sub-module multi_trig_ch: one channel's window comparator, output register and edge detector.
  - Instantiated N_CH times, plus once for prf with enable tied high and delay tied to 0.

Test Plan:
- Reset, then update with period=10, prf_width=2, delay0=3, width0=4, ch_en=0001 -> prf high at cnt 0-1; tr[0] high at cnt 3-6; tr_edge[0] rise/fall flags exactly once per frame; applied pulses once.
- delay1=8, width1=5, period=10 -> tr[1] high at cnt 8-9 only, with no carry into cnt 0-2 of the next frame.
- Update with period=20 issued mid-frame (cnt=4) of a period-10 frame -> the old frame completes 10 cycles; the new period starts at the wrap; no glitch on tr.
- Two updates before the wrap (delay0=2, then delay0=5) -> only delay0=5 takes effect.
- ct_num=25 with period=10 -> ct high for exactly 25 cycles from the first frame start; a re-update reloads it.
- Update with period=0 while running -> at the wrap all outputs go to 0 and running = 0.
  - With the burst macro defined: burst_num=3 gives 3 prf pulses, then burst_done.
